cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Exception and interrupt sequencer for the five-stage MIPS pipeline. It owns the CP0 Status/Cause/EPC registers and services mfc0/mtc0 from the MEM stage. It takes syscall and external interrupts precisely at the MEM stage, then drives a multi-cycle flush/redirect sequence into the PC and pipeline-register control. The mfc0 bubble logic in the hazard unit depends on this block's read timing: mfc0 data is only valid in MEM.

## Interface
Parameters:
- NIRQ, 4: number of external interrupt lines (1..8).
- VECTOR_ADDR, 32'h0000_4180: handler entry PC.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  NIRQ  level-sensitive interrupt requests.
- mem_valid  in  1  MEM stage holds a real instruction (not a bubble).
- mem_cp0Op  in  3  000 none, 001 mfc0, 010 mtc0, 011 eret, 100 syscall.
- mem_pc  in  32  PC of the MEM-stage instruction.
- mem_rd  in  5  CP0 register index (12 Status, 13 Cause, 14 EPC).
- mem_wdata  in  32  mtc0 write data.
- cp0_rdata  out  32  mfc0 read data, combinational from mem_rd.
- flush  out  1  kill all instructions in IF..MEM.
- redirect  out  1  load redirect_pc into PC this cycle.
- redirect_pc  out  32  target PC; 0 when redirect=0.
- status, cause, epc  out  32 each  current register values.
- in_handler  out  1  set from exception entry until eret completes.

## Operation
- Status: bit0 IE; bits [8+NIRQ-1:8] IM; all other bits read 0 and ignore writes.
- Cause: bits [8+NIRQ-1:8] IP, loaded every cycle from the (optionally synchronised) irq; bits [6:2] ExcCode (0 interrupt, 8 syscall). Cause is read-only to mtc0.
- EPC: full 32-bit, writable by mtc0.
- mfc0 to an unimplemented index reads 0. mtc0 to an unimplemented index is ignored.
- FSM states are RUN, SAVE, VEC and ERET.
- In RUN, with mem_valid=1, the first matching condition in this list applies:
  - syscall: EPC←mem_pc+4, ExcCode←8, IE←0, go to SAVE.
  - pending interrupt, i.e. IE=1 and (IP&IM)≠0: EPC←mem_pc, ExcCode←0, IE←0, go to SAVE. The MEM instruction is killed and later re-executed.
  - eret: go to ERET.
  - mtc0: write the register at the edge.
- In RUN with mem_valid=0, no exception is taken and mtc0 is ignored.
- SAVE: flush=1, then go to VEC.
- VEC: flush=1, redirect=1, redirect_pc=VECTOR_ADDR, then go to RUN.
- ERET: flush=1, redirect=1, redirect_pc=EPC, IE←1, in_handler←0, then go to RUN.
- in_handler←1 on the RUN→SAVE edge.
- All mem_* inputs are ignored in SAVE, VEC and ERET.
- Simultaneous events:
  - syscall beats a pending interrupt.
  - An interrupt beats an mtc0 in the same cycle; the mtc0 is discarded.
  - An interrupt arriving during ERET is taken no earlier than the first valid RUN cycle after return.
  - An mtc0 that sets IE=1 while IP&IM≠0 takes effect at the edge. The interrupt is taken on the next valid RUN cycle.

## Timing
- Reset values: Status=0, Cause=0, EPC=0, state=RUN, flush=0, redirect=0, redirect_pc=0, in_handler=0.
- Reset is asynchronous and aborts any sequence; outputs return to reset values immediately.
- cp0_rdata has zero latency: it reflects register contents before the current edge's write.
- Exception latency: detected in cycle t, flush in t+1..t+2, redirect in t+2, handler fetch in t+3.
- eret latency: detected in cycle t, flush+redirect in t+1.
- IP sampling: 1 cycle from irq to Cause.IP without sync.

## Configuration
- CP0_IRQ_SYNC_EN defined: irq passes through a two-flop synchroniser (reset to 0) before IP. irq→IP latency is 3 cycles.
- CP0_IRQ_SYNC_EN undefined: irq is registered directly into IP with 1-cycle latency.

## Test plan
- mtc0 Status←32'h0000_0F01 (NIRQ=4), then mfc0 12 → 32'h0000_0F01. mtc0 Cause←32'hFFFF_FFFF leaves Cause=0.
- syscall at mem_pc=32'h0000_3010 → EPC=32'h0000_3014, Cause[6:2]=8, IE=0, flush in 2 cycles, redirect_pc=32'h0000_4180, in_handler=1.
- IE=1, IM=4'b0100, irq=4'b0100, mem_pc=32'h0000_3020 valid → EPC=32'h0000_3020, ExcCode=0. Same stimulus with IM=0 → no exception.
- eret with EPC=32'h0000_3020 → one cycle of flush+redirect to 32'h0000_3020, IE=1, in_handler=0.
- syscall and pending interrupt in the same cycle → ExcCode=8, EPC=mem_pc+4. Interrupt taken after eret, on the first valid cycle.
- rst asserted during VEC → flush and redirect drop to 0 without waiting for a clock edge, and all registers read 0.

Source files
------------

// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// =====================================================================
// cp0_exc_ctrl_if : MEM-stage CP0 access and flush/redirect bundle.
// Rev 1.0
// =====================================================================
interface cp0_exc_ctrl_if #(
  parameter int NIRQ = 4
);
  logic [NIRQ-1:0] irq;
  logic            mem_valid;
  logic [2:0]      mem_cp0Op;
  logic [31:0]     mem_pc;
  logic [4:0]      mem_rd;
  logic [31:0]     mem_wdata;
  logic [31:0]     cp0_rdata;
  logic            flush;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic [31:0]     status;
  logic [31:0]     cause;
  logic [31:0]     epc;
  logic            in_handler;

  modport master (
    output irq, mem_valid, mem_cp0Op, mem_pc, mem_rd, mem_wdata,
    input  cp0_rdata, flush, redirect, redirect_pc, status, cause, epc, in_handler
  );

  modport slave (
    input  irq, mem_valid, mem_cp0Op, mem_pc, mem_rd, mem_wdata,
    output cp0_rdata, flush, redirect, redirect_pc, status, cause, epc, in_handler
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// =====================================================================
// cp0_exc_ctrl : CP0 Status/Cause/EPC and precise exception sequencer.
// Optional irq synchroniser enabled by CP0_IRQ_SYNC_EN. Rev 1.0
// =====================================================================
module cp0_exc_ctrl #(
  parameter int          NIRQ        = 4,
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          rst,
  cp0_exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SAVE = 2'd1,
    ST_VEC  = 2'd2,
    ST_ERET = 2'd3
  } state_e;

  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_ERET    = 3'b011;
  localparam logic [2:0] OP_SYSCALL = 3'b100;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] EXC_INT    = 5'd0;
  localparam logic [4:0] EXC_SYS    = 5'd8;

  state_e          state_q, state_d;
  logic            ie_q, ie_d;
  logic [NIRQ-1:0] im_q, im_d;
  logic [NIRQ-1:0] ip_q;
  logic [4:0]      exc_q, exc_d;
  logic [31:0]     epc_q, epc_d;
  logic            inh_q, inh_d;
  logic [NIRQ-1:0] irq_s_w;
  logic [31:0]     status_w, cause_w, rdata_w, rpc_w;
  logic            pending_w, flush_w, redirect_w;

`ifdef CP0_IRQ_SYNC_EN
  logic [NIRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.irq;
      sync2_q <= sync1_q;
    end
  end
  assign irq_s_w = sync2_q;
`else
  assign irq_s_w = bus.irq;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ie_q    <= 1'b0;
      im_q    <= '0;
      ip_q    <= '0;
      exc_q   <= '0;
      epc_q   <= '0;
      inh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      im_q    <= im_d;
      ip_q    <= irq_s_w;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
      inh_q   <= inh_d;
    end
  end

  always_comb begin
    status_w          = '0;
    status_w[0]       = ie_q;
    status_w[8+:NIRQ] = im_q;
    cause_w           = '0;
    cause_w[8+:NIRQ]  = ip_q;
    cause_w[6:2]      = exc_q;
  end

  assign pending_w = ie_q && (|(ip_q & im_q));

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    im_d       = im_q;
    exc_d      = exc_q;
    epc_d      = epc_q;
    inh_d      = inh_q;
    flush_w    = 1'b0;
    redirect_w = 1'b0;
    rpc_w      = '0;
    case (state_q)
      ST_RUN: begin
        // Priority: syscall, interrupt (kills MEM instr and any mtc0), eret, mtc0
        if (bus.mem_valid) begin
          if (bus.mem_cp0Op == OP_SYSCALL) begin
            epc_d   = bus.mem_pc + 32'd4;
            exc_d   = EXC_SYS;
            ie_d    = 1'b0;
            inh_d   = 1'b1;
            state_d = ST_SAVE;
          end else if (pending_w) begin
            epc_d   = bus.mem_pc;
            exc_d   = EXC_INT;
            ie_d    = 1'b0;
            inh_d   = 1'b1;
            state_d = ST_SAVE;
          end else if (bus.mem_cp0Op == OP_ERET) begin
            state_d = ST_ERET;
          end else if (bus.mem_cp0Op == OP_MTC0) begin
            case (bus.mem_rd)
              REG_STATUS: begin
                ie_d = bus.mem_wdata[0];
                im_d = bus.mem_wdata[8+:NIRQ];
              end
              REG_EPC: epc_d = bus.mem_wdata;
              default: ;
            endcase
          end
        end
      end
      ST_SAVE: begin
        flush_w = 1'b1;
        state_d = ST_VEC;
      end
      ST_VEC: begin
        flush_w    = 1'b1;
        redirect_w = 1'b1;
        rpc_w      = VECTOR_ADDR;
        state_d    = ST_RUN;
      end
      ST_ERET: begin
        flush_w    = 1'b1;
        redirect_w = 1'b1;
        rpc_w      = epc_q;
        ie_d       = 1'b1;
        inh_d      = 1'b0;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rdata_w = '0;
    case (bus.mem_rd)
      REG_STATUS: rdata_w = status_w;
      REG_CAUSE:  rdata_w = cause_w;
      REG_EPC:    rdata_w = epc_q;
      default:    rdata_w = '0;
    endcase
  end

  assign bus.cp0_rdata   = rdata_w;
  assign bus.flush       = flush_w;
  assign bus.redirect    = redirect_w;
  assign bus.redirect_pc = rpc_w;
  assign bus.status      = status_w;
  assign bus.cause       = cause_w;
  assign bus.epc         = epc_q;
  assign bus.in_handler  = inh_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// =====================================================================
// tb_cp0_exc_ctrl : scoreboard bench for cp0_exc_ctrl.
// Rev 1.0
// =====================================================================
module tb_cp0_exc_ctrl;

  localparam int          NIRQ = 4;
  localparam logic [31:0] VEC  = 32'h0000_4180;
`ifdef CP0_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_MFC0 = 3'b001;
  localparam logic [2:0] OP_MTC0 = 3'b010;
  localparam logic [2:0] OP_ERET = 3'b011;
  localparam logic [2:0] OP_SYS  = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_exc_ctrl_if #(.NIRQ(NIRQ)) cp0_if ();

  cp0_exc_ctrl #(.NIRQ(NIRQ), .VECTOR_ADDR(VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cp0_if)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t redir_q[$];
  exp_t rd_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_redir(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    redir_q.push_back(e);
  endtask

  // Every redirect the DUT issues must match the next queued target.
  always @(negedge clk) begin
    if (rst === 1'b0 && cp0_if.redirect === 1'b1) begin
      if (redir_q.size() == 0) begin
        check_eq("redir_unexpected", {31'b0, cp0_if.redirect}, 32'd0);
      end else begin
        exp_t e;
        e = redir_q.pop_front();
        check_eq(e.tag, cp0_if.redirect_pc, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] wd);
    cp0_if.mem_valid = v;
    cp0_if.mem_cp0Op = op;
    cp0_if.mem_rd    = rd;
    cp0_if.mem_pc    = pc;
    cp0_if.mem_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, OP_NONE, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic mfc0_chk(input string tag, input logic [4:0] rd, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    drive(1'b1, OP_MFC0, rd, 32'h0000_3000, 32'h0);
    rd_q.push_back(e);
    #1;
    e = rd_q.pop_front();
    check_eq(e.tag, cp0_if.cp0_rdata, e.val);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cp0_if.irq = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_status", cp0_if.status, 32'h0);
    check_eq("rst_cause", cp0_if.cause, 32'h0);
    check_eq("rst_epc", cp0_if.epc, 32'h0);
    check_eq("rst_flush", {31'b0, cp0_if.flush}, 32'd0);
    check_eq("rst_redirect", {31'b0, cp0_if.redirect}, 32'd0);
    check_eq("rst_rpc", cp0_if.redirect_pc, 32'h0);
    check_eq("rst_inh", {31'b0, cp0_if.in_handler}, 32'd0);
    rst = 1'b0;
    step();

    // register access
    drive(1'b1, OP_MTC0, 5'd12, 32'h0000_3000, 32'h0000_0F01); step(); idle();
    mfc0_chk("mfc0_status", 5'd12, 32'h0000_0F01);
    drive(1'b1, OP_MTC0, 5'd13, 32'h0000_3004, 32'hFFFF_FFFF); step(); idle();
    mfc0_chk("mfc0_cause_ro", 5'd13, 32'h0);
    drive(1'b1, OP_MTC0, 5'd14, 32'h0000_3008, 32'h1234_5678); step(); idle();
    mfc0_chk("mfc0_epc", 5'd14, 32'h1234_5678);
    mfc0_chk("mfc0_unimpl", 5'd5, 32'h0);

    // syscall
    push_redir("redir_sys", VEC);
    drive(1'b1, OP_SYS, 5'd0, 32'h0000_3010, 32'h0); step();
    drive(1'b1, OP_MTC0, 5'd14, 32'h0000_3014, 32'hDEAD_BEEF);
    check_eq("sys_flush_save", {31'b0, cp0_if.flush}, 32'd1);
    check_eq("sys_redir_save", {31'b0, cp0_if.redirect}, 32'd0);
    check_eq("sys_epc", cp0_if.epc, 32'h0000_3014);
    check_eq("sys_exc", {27'b0, cp0_if.cause[6:2]}, 32'd8);
    check_eq("sys_ie", {31'b0, cp0_if.status[0]}, 32'd0);
    check_eq("sys_inh", {31'b0, cp0_if.in_handler}, 32'd1);
    step(); idle();
    check_eq("sys_flush_vec", {31'b0, cp0_if.flush}, 32'd1);
    check_eq("sys_redir_vec", {31'b0, cp0_if.redirect}, 32'd1);
    check_eq("save_ignores_mtc0", cp0_if.epc, 32'h0000_3014);
    step();
    check_eq("sys_flush_done", {31'b0, cp0_if.flush}, 32'd0);

    // interrupt, IM=0100
    drive(1'b1, OP_MTC0, 5'd12, 32'h0000_3018, 32'h0000_0401); step(); idle();
    cp0_if.irq = 4'b0100;
    repeat (IRQ_LAT + 1) step();
    check_eq("int_cause_ip", cp0_if.cause, 32'h0000_0420);
    check_eq("int_no_exc_invalid", {31'b0, cp0_if.flush}, 32'd0);
    push_redir("redir_int", VEC);
    drive(1'b1, OP_NONE, 5'd0, 32'h0000_3020, 32'h0); step(); idle();
    check_eq("int_flush", {31'b0, cp0_if.flush}, 32'd1);
    check_eq("int_epc", cp0_if.epc, 32'h0000_3020);
    check_eq("int_exc", {27'b0, cp0_if.cause[6:2]}, 32'd0);
    step(); step();
    check_eq("int_status", cp0_if.status, 32'h0000_0400);

    // same stimulus with IM=0
    drive(1'b1, OP_MTC0, 5'd12, 32'h0000_3018, 32'h0000_0001); step();
    drive(1'b1, OP_NONE, 5'd0, 32'h0000_3020, 32'h0); step(); idle();
    check_eq("im0_no_flush", {31'b0, cp0_if.flush}, 32'd0);

    // eret
    cp0_if.irq = 4'b0000;
    drive(1'b1, OP_MTC0, 5'd12, 32'h0000_3024, 32'h0000_0400); step(); idle();
    repeat (IRQ_LAT + 1) step();
    push_redir("redir_eret", 32'h0000_3020);
    drive(1'b1, OP_ERET, 5'd0, 32'h0000_3028, 32'h0); step(); idle();
    check_eq("eret_flush", {31'b0, cp0_if.flush}, 32'd1);
    check_eq("eret_redirect", {31'b0, cp0_if.redirect}, 32'd1);
    step();
    check_eq("eret_status", cp0_if.status, 32'h0000_0401);
    check_eq("eret_inh", {31'b0, cp0_if.in_handler}, 32'd0);
    check_eq("eret_flush_done", {31'b0, cp0_if.flush}, 32'd0);

    // syscall beats pending interrupt
    cp0_if.irq = 4'b0100;
    repeat (IRQ_LAT + 1) step();
    push_redir("redir_sysint", VEC);
    drive(1'b1, OP_SYS, 5'd0, 32'h0000_3040, 32'h0); step(); idle();
    check_eq("sysint_exc", {27'b0, cp0_if.cause[6:2]}, 32'd8);
    check_eq("sysint_epc", cp0_if.epc, 32'h0000_3044);
    step(); step();
    push_redir("redir_eret2", 32'h0000_3044);
    drive(1'b1, OP_ERET, 5'd0, 32'h0000_3048, 32'h0); step();
    drive(1'b1, OP_NONE, 5'd0, 32'h0000_3099, 32'h0); step(); idle();
    check_eq("post_eret_no_exc", {31'b0, cp0_if.flush}, 32'd0);
    step();
    check_eq("post_eret_idle", cp0_if.epc, 32'h0000_3044);
    push_redir("redir_int2", VEC);
    drive(1'b1, OP_NONE, 5'd0, 32'h0000_3050, 32'h0); step(); idle();
    check_eq("int2_epc", cp0_if.epc, 32'h0000_3050);
    check_eq("int2_exc", {27'b0, cp0_if.cause[6:2]}, 32'd0);
    step(); step();

    // mtc0 enabling IE while pending; next valid cycle takes interrupt over mtc0
    drive(1'b1, OP_MTC0, 5'd12, 32'h0000_3058, 32'h0000_0401); step();
    push_redir("redir_int3", VEC);
    drive(1'b1, OP_MTC0, 5'd14, 32'h0000_3060, 32'h0000_AAAA); step(); idle();
    check_eq("int_beats_mtc0", cp0_if.epc, 32'h0000_3060);
    check_eq("int3_flush", {31'b0, cp0_if.flush}, 32'd1);
    step(); step();

    // async reset during VEC
    cp0_if.irq = 4'b0000;
    drive(1'b1, OP_SYS, 5'd0, 32'h0000_3070, 32'h0); step(); idle();
    step();
    check_eq("vec_pre_reset", {31'b0, cp0_if.redirect}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_flush", {31'b0, cp0_if.flush}, 32'd0);
    check_eq("arst_redirect", {31'b0, cp0_if.redirect}, 32'd0);
    check_eq("arst_rpc", cp0_if.redirect_pc, 32'h0);
    check_eq("arst_status", cp0_if.status, 32'h0);
    check_eq("arst_cause", cp0_if.cause, 32'h0);
    check_eq("arst_epc", cp0_if.epc, 32'h0);
    check_eq("arst_inh", {31'b0, cp0_if.in_handler}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("redir_sb_drained", redir_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
